tlb_port_arbiter: RTL and testbench

- Single-cycle arbiter sharing one cva6_tlb_sv32 instance between four requesters:
  - two lookup requesters (port 0 = instruction side, port 1 = data side);
  - one update requester (page-table walker refill);
  - one flush requester (SFENCE.VMA).
- Drives the TLB flush, update and lookup inputs, registers the lookup result, and returns it to the granted requester one cycle later.
- Sits between the MMU front ends and the TLB.

---
 rtl/tlb_arb_pkg.sv | 39 +++
 rtl/tlb_lu_rr_select.sv | 56 +++++
 rtl/tlb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_tlb_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_arb_pkg.sv
// rtl/tlb_arb_pkg.sv - shared types and update-vector layout for the TLB port arbiter
package tlb_arb_pkg;

    localparam int UPD_W          = 63;
    localparam int UPD_VALID      = 62;
    localparam int UPD_IS4M       = 61;
    localparam int UPD_VPN_HI     = 60;
    localparam int UPD_VPN_LO     = 41;
    localparam int UPD_ASID_HI    = 40;
    localparam int UPD_ASID_LO    = 32;
    localparam int UPD_CONTENT_HI = 31;
    localparam int UPD_CONTENT_LO = 0;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_FLUSH,
        GNT_UPDATE,
        GNT_LU0,
        GNT_LU1
    } grant_e;

    // Build a valid TLB update vector from its fields
    function automatic logic [UPD_W-1:0] pack_update(
        input logic        is_4m,
        input logic [19:0] vpn,
        input logic [8:0]  asid,
        input logic [31:0] content
    );
        logic [UPD_W-1:0] v;
        v                                 = '0;
        v[UPD_VALID]                      = 1'b1;
        v[UPD_IS4M]                       = is_4m;
        v[UPD_VPN_HI:UPD_VPN_LO]          = vpn;
        v[UPD_ASID_HI:UPD_ASID_LO]        = asid;
        v[UPD_CONTENT_HI:UPD_CONTENT_LO]  = content;
        return v;
    endfunction

endpackage

// File: rtl/tlb_lu_rr_select.sv
// rtl/tlb_lu_rr_select.sv - two-port lookup round-robin with starvation counters
module tlb_lu_rr_select
    import tlb_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] i_req,
    input  logic       i_lu_gnt,
    output logic       o_valid,
    output logic       o_port,
    output logic       o_starved
);
    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic                r_ptr;
    logic [1:0][CW-1:0]  r_wait;
    logic [1:0]          w_starved;

    // Pick a port: starved ports first, round-robin pointer breaks ties
    always_comb begin
        w_starved[0] = i_req[0] && (r_wait[0] == WAIT_MAX);
        w_starved[1] = i_req[1] && (r_wait[1] == WAIT_MAX);
        o_valid      = |i_req;
        o_starved    = |w_starved;
        if (w_starved == 2'b11)      o_port = r_ptr;
        else if (w_starved[0])       o_port = 1'b0;
        else if (w_starved[1])       o_port = 1'b1;
        else if (i_req == 2'b11)     o_port = r_ptr;
        else                         o_port = i_req[1] && !i_req[0];
    end

    // Per-port wait counters: count lost cycles, clear on grant or idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!i_req[p] || (i_lu_gnt && (o_port == 1'(p))))
                    r_wait[p] <= '0;
                else if (r_wait[p] != WAIT_MAX)
                    r_wait[p] <= r_wait[p] + ONE;
            end
        end
    end

    // After a lookup grant the other port becomes preferred
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_ptr <= 1'b0;
        else if (i_lu_gnt) r_ptr <= ~o_port;
    end

endmodule

// File: rtl/tlb_port_arbiter.sv
// rtl/tlb_port_arbiter.sv - shares one TLB between flush, update and two lookup requesters
module tlb_port_arbiter
    import tlb_arb_pkg::*;
#(
    parameter int ASID_WIDTH = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_req_i,
    input  logic [31:0]                  flush_vaddr_i,
    input  logic [ASID_WIDTH-1:0]        flush_asid_i,
    output logic                         flush_ack_o,
    input  logic                         upd_req_i,
    input  logic                         upd_is_4M_i,
    input  logic [19:0]                  upd_vpn_i,
    input  logic [8:0]                   upd_asid_i,
    input  logic [31:0]                  upd_content_i,
    output logic                         upd_ack_o,
    input  logic [1:0]                   lu_req_i,
    input  logic [1:0][31:0]             lu_vaddr_i,
    input  logic [1:0][ASID_WIDTH-1:0]   lu_asid_i,
    output logic [1:0]                   lu_ack_o,
    output logic [1:0]                   rsp_valid_o,
    output logic                         rsp_hit_o,
    output logic                         rsp_is_4M_o,
    output logic [31:0]                  rsp_content_o,
    output logic                         tlb_flush_o,
    output logic [UPD_W-1:0]             tlb_update_o,
    output logic                         tlb_lu_access_o,
    output logic [ASID_WIDTH-1:0]        tlb_lu_asid_o,
    output logic [31:0]                  tlb_lu_vaddr_o,
    output logic [ASID_WIDTH-1:0]        tlb_asid_to_be_flushed_o,
    output logic [31:0]                  tlb_vaddr_to_be_flushed_o,
    input  logic [31:0]                  tlb_lu_content_i,
    input  logic                         tlb_lu_hit_i,
    input  logic                         tlb_lu_is_4M_i
);
    grant_e      w_gnt;
    logic        w_lu_valid;
    logic        w_lu_port;
    logic        w_lu_starved;
    logic        w_lu_gnt;
    logic [1:0]  r_rsp_valid;
    logic        r_rsp_hit;
    logic        r_rsp_is_4m;
    logic [31:0] r_rsp_content;

    tlb_lu_rr_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_req     (lu_req_i),
        .i_lu_gnt  (w_lu_gnt),
        .o_valid   (w_lu_valid),
        .o_port    (w_lu_port),
        .o_starved (w_lu_starved)
    );

    // Fixed-priority grant; reset forces no grant so acks and TLB drives stay low
    always_comb begin
        w_gnt = GNT_NONE;
        if (!rst_ni)                      w_gnt = GNT_NONE;
        else if (flush_req_i)             w_gnt = GNT_FLUSH;
        else if (w_lu_valid && w_lu_starved) w_gnt = w_lu_port ? GNT_LU1 : GNT_LU0;
        else if (upd_req_i)               w_gnt = GNT_UPDATE;
        else if (w_lu_valid)              w_gnt = w_lu_port ? GNT_LU1 : GNT_LU0;
    end

    assign w_lu_gnt = (w_gnt == GNT_LU0) || (w_gnt == GNT_LU1);

    // Acks and TLB drives follow the grant; everything idles at zero
    always_comb begin
        flush_ack_o               = 1'b0;
        upd_ack_o                 = 1'b0;
        lu_ack_o                  = 2'b00;
        tlb_flush_o               = 1'b0;
        tlb_update_o              = '0;
        tlb_lu_access_o           = 1'b0;
        tlb_lu_asid_o             = '0;
        tlb_lu_vaddr_o            = '0;
        tlb_asid_to_be_flushed_o  = '0;
        tlb_vaddr_to_be_flushed_o = '0;
        case (w_gnt)
            GNT_FLUSH: begin
                flush_ack_o               = 1'b1;
                tlb_flush_o               = 1'b1;
                tlb_asid_to_be_flushed_o  = flush_asid_i;
                tlb_vaddr_to_be_flushed_o = flush_vaddr_i;
            end
            GNT_UPDATE: begin
                upd_ack_o    = 1'b1;
                tlb_update_o = pack_update(upd_is_4M_i, upd_vpn_i, upd_asid_i, upd_content_i);
            end
            GNT_LU0, GNT_LU1: begin
                lu_ack_o        = (w_gnt == GNT_LU1) ? 2'b10 : 2'b01;
                tlb_lu_access_o = 1'b1;
                tlb_lu_asid_o   = lu_asid_i[w_lu_port];
                tlb_lu_vaddr_o  = lu_vaddr_i[w_lu_port];
            end
            default: ;
        endcase
    end

    // Capture the TLB lookup result and flag the granted port for one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid   <= 2'b00;
            r_rsp_hit     <= 1'b0;
            r_rsp_is_4m   <= 1'b0;
            r_rsp_content <= '0;
        end else begin
            r_rsp_valid <= {w_gnt == GNT_LU1, w_gnt == GNT_LU0};
            if (w_lu_gnt) begin
                r_rsp_hit     <= tlb_lu_hit_i;
                r_rsp_is_4m   <= tlb_lu_is_4M_i;
                r_rsp_content <= tlb_lu_content_i;
            end
        end
    end

    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_hit_o     = r_rsp_hit;
    assign rsp_is_4M_o   = r_rsp_is_4m;
    assign rsp_content_o = r_rsp_content;

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// tb/tb_tlb_port_arbiter.sv - scoreboard bench for tlb_port_arbiter
module tb_tlb_port_arbiter;
    import tlb_arb_pkg::*;

    localparam int AW = 1;
    localparam int MW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_req_i = 1'b0;
    logic [31:0]      flush_vaddr_i = '0;
    logic [AW-1:0]    flush_asid_i = '0;
    logic             flush_ack_o;
    logic             upd_req_i = 1'b0;
    logic             upd_is_4M_i = 1'b0;
    logic [19:0]      upd_vpn_i = '0;
    logic [8:0]       upd_asid_i = '0;
    logic [31:0]      upd_content_i = '0;
    logic             upd_ack_o;
    logic [1:0]       lu_req_i = '0;
    logic [1:0][31:0] lu_vaddr_i = '0;
    logic [1:0][AW-1:0] lu_asid_i = '0;
    logic [1:0]       lu_ack_o;
    logic [1:0]       rsp_valid_o;
    logic             rsp_hit_o;
    logic             rsp_is_4M_o;
    logic [31:0]      rsp_content_o;
    logic             tlb_flush_o;
    logic [62:0]      tlb_update_o;
    logic             tlb_lu_access_o;
    logic [AW-1:0]    tlb_lu_asid_o;
    logic [31:0]      tlb_lu_vaddr_o;
    logic [AW-1:0]    tlb_asid_to_be_flushed_o;
    logic [31:0]      tlb_vaddr_to_be_flushed_o;
    logic [31:0]      tlb_lu_content_i;
    logic             tlb_lu_hit_i;
    logic             tlb_lu_is_4M_i;

    always #5 clk = ~clk;

    tlb_port_arbiter #(.ASID_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_req_i(flush_req_i), .flush_vaddr_i(flush_vaddr_i), .flush_asid_i(flush_asid_i),
        .flush_ack_o(flush_ack_o),
        .upd_req_i(upd_req_i), .upd_is_4M_i(upd_is_4M_i), .upd_vpn_i(upd_vpn_i),
        .upd_asid_i(upd_asid_i), .upd_content_i(upd_content_i), .upd_ack_o(upd_ack_o),
        .lu_req_i(lu_req_i), .lu_vaddr_i(lu_vaddr_i), .lu_asid_i(lu_asid_i), .lu_ack_o(lu_ack_o),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_is_4M_o(rsp_is_4M_o),
        .rsp_content_o(rsp_content_o),
        .tlb_flush_o(tlb_flush_o), .tlb_update_o(tlb_update_o), .tlb_lu_access_o(tlb_lu_access_o),
        .tlb_lu_asid_o(tlb_lu_asid_o), .tlb_lu_vaddr_o(tlb_lu_vaddr_o),
        .tlb_asid_to_be_flushed_o(tlb_asid_to_be_flushed_o),
        .tlb_vaddr_to_be_flushed_o(tlb_vaddr_to_be_flushed_o),
        .tlb_lu_content_i(tlb_lu_content_i), .tlb_lu_hit_i(tlb_lu_hit_i),
        .tlb_lu_is_4M_i(tlb_lu_is_4M_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- TLB stand-in: 8 entries, combinational lookup, writes at the edge
    logic        e_v [8];
    logic        e_4m[8];
    logic [19:0] e_vpn[8];
    logic [8:0]  e_asid[8];
    logic [31:0] e_data[8];

    initial for (int i = 0; i < 8; i++) e_v[i] = 1'b0;

    always_comb begin
        tlb_lu_hit_i     = 1'b0;
        tlb_lu_is_4M_i   = 1'b0;
        tlb_lu_content_i = '0;
        for (int i = 0; i < 8; i++) begin
            if (tlb_lu_access_o && e_v[i] && (e_asid[i][AW-1:0] == tlb_lu_asid_o) &&
                (e_vpn[i][19:10] == tlb_lu_vaddr_o[31:22]) &&
                (e_4m[i] || (e_vpn[i][9:0] == tlb_lu_vaddr_o[21:12]))) begin
                tlb_lu_hit_i     = 1'b1;
                tlb_lu_is_4M_i   = e_4m[i];
                tlb_lu_content_i = e_data[i];
            end
        end
    end

    always @(posedge clk) begin : env_wr
        int slot;
        if (tlb_flush_o) begin
            for (int i = 0; i < 8; i++) e_v[i] <= 1'b0;
        end else if (tlb_update_o[62]) begin
            slot = -1;
            for (int i = 0; i < 8; i++)
                if (slot < 0 && e_v[i] && e_vpn[i] == tlb_update_o[60:41] && e_asid[i] == tlb_update_o[40:32]) slot = i;
            for (int i = 0; i < 8; i++)
                if (slot < 0 && !e_v[i]) slot = i;
            if (slot < 0) slot = 0;
            e_v[slot]    <= 1'b1;
            e_4m[slot]   <= tlb_update_o[61];
            e_vpn[slot]  <= tlb_update_o[60:41];
            e_asid[slot] <= tlb_update_o[40:32];
            e_data[slot] <= tlb_update_o[31:0];
        end
    end

    // ---------------- reference model
    typedef struct {
        logic [3:0]  ack;
        logic        flush;
        logic [31:0] fl_vaddr;
        logic [AW-1:0] fl_asid;
        logic [62:0] upd;
        logic        lu_acc;
        logic [31:0] lu_vaddr;
        logic [AW-1:0] lu_asid;
    } exp_t;

    typedef struct {
        logic [1:0]  valid;
        logic        hit;
        logic        big;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        int          vpn;
        int          asid;
        bit          big;
        logic [31:0] data;
    } ref_ent_t;

    exp_t     exp_q[$];
    rsp_t     rsp_q[$];
    ref_ent_t rtlb[$];
    int       glog[$];
    int       wcnt[2];
    int       ptr;
    logic [3:0] s_ack = '0;

    function automatic void ref_lookup(input logic [31:0] va, input int asid,
                                       output bit hit, output bit big, output logic [31:0] data);
        int page;
        page = int'(va >> 12);
        hit = 0; big = 0; data = '0;
        foreach (rtlb[i]) begin
            if (rtlb[i].asid == asid &&
                (rtlb[i].big ? ((rtlb[i].vpn >> 10) == (page >> 10)) : (rtlb[i].vpn == page))) begin
                hit = 1; big = rtlb[i].big; data = rtlb[i].data;
            end
        end
    endfunction

    function automatic void ref_update(input int vpn, input int asid, input bit big, input logic [31:0] data);
        ref_ent_t n;
        for (int i = rtlb.size() - 1; i >= 0; i--)
            if (rtlb[i].vpn == vpn && rtlb[i].asid == asid) rtlb.delete(i);
        n.vpn = vpn; n.asid = asid; n.big = big; n.data = data;
        rtlb.push_back(n);
    endfunction

    // Predict this cycle's grant from the priority rules and queue the expectations
    always @(negedge clk) begin : model
        int  kind;
        int  port;
        bit  st0, st1, h, b;
        logic [31:0] d;
        exp_t e;
        rsp_t r;
        if (!rst_n) begin
            wcnt[0] = 0; wcnt[1] = 0; ptr = 0;
            exp_q.delete(); rsp_q.delete();
        end else begin
            kind = 0; port = 0;
            st0 = lu_req_i[0] && (wcnt[0] == MW);
            st1 = lu_req_i[1] && (wcnt[1] == MW);
            if (flush_req_i) kind = 1;
            else if (st0 || st1) begin
                port = (st0 && st1) ? ptr : (st0 ? 0 : 1);
                kind = 3 + port;
            end else if (upd_req_i) kind = 2;
            else if (lu_req_i != 2'b00) begin
                port = (lu_req_i == 2'b11) ? ptr : (lu_req_i[0] ? 0 : 1);
                kind = 3 + port;
            end
            for (int p = 0; p < 2; p++) begin
                if (!lu_req_i[p] || kind == 3 + p) wcnt[p] = 0;
                else if (wcnt[p] < MW) wcnt[p] = wcnt[p] + 1;
            end
            if (kind >= 3) ptr = 1 - port;
            e.ack      = (kind == 1) ? 4'b1000 : (kind == 2) ? 4'b0100 :
                         (kind == 3) ? 4'b0001 : (kind == 4) ? 4'b0010 : 4'b0000;
            e.flush    = (kind == 1);
            e.fl_vaddr = (kind == 1) ? flush_vaddr_i : 32'd0;
            e.fl_asid  = (kind == 1) ? flush_asid_i : '0;
            e.upd      = (kind == 2) ? {1'b1, upd_is_4M_i, upd_vpn_i, upd_asid_i, upd_content_i} : 63'd0;
            e.lu_acc   = (kind >= 3);
            e.lu_vaddr = (kind >= 3) ? lu_vaddr_i[port] : 32'd0;
            e.lu_asid  = (kind >= 3) ? lu_asid_i[port] : '0;
            exp_q.push_back(e);
            if (kind >= 3) begin
                ref_lookup(lu_vaddr_i[port], int'(lu_asid_i[port]), h, b, d);
                r.valid = (kind == 3) ? 2'b01 : 2'b10;
                r.hit = h; r.big = b; r.data = d;
                rsp_q.push_back(r);
            end
            if (kind == 2) ref_update(int'(upd_vpn_i), int'(upd_asid_i) % 2, upd_is_4M_i, upd_content_i);
            if (kind == 1) rtlb.delete();
        end
    end

    // Monitor: compare DUT outputs against the queued expectations
    always @(negedge clk) begin : monitor
        exp_t e;
        rsp_t r;
        logic [3:0] a;
        #1;
        a = {flush_ack_o, upd_ack_o, lu_ack_o};
        s_ack = a;
        if (!rst_n) begin
            chk("rst_acks", a, 0);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            chk("rst_rsp_data", {rsp_hit_o, rsp_is_4M_o, rsp_content_o}, 0);
            chk("rst_tlb_out", {tlb_flush_o, tlb_lu_access_o, tlb_lu_asid_o, tlb_asid_to_be_flushed_o}, 0);
            chk("rst_tlb_vec", {tlb_update_o[62:32] | tlb_update_o[31:0], tlb_lu_vaddr_o | tlb_vaddr_to_be_flushed_o}, 0);
        end else begin
            if (exp_q.size() == 0) chk("exp_q_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("ack", a, e.ack);
                chk("tlb_flush", {tlb_flush_o, tlb_vaddr_to_be_flushed_o, tlb_asid_to_be_flushed_o},
                    {e.flush, e.fl_vaddr, e.fl_asid});
                chk("tlb_update", tlb_update_o, e.upd);
                chk("tlb_lookup", {tlb_lu_access_o, tlb_lu_vaddr_o, tlb_lu_asid_o},
                    {e.lu_acc, e.lu_vaddr, e.lu_asid});
            end
            if (a != 4'b0000)
                glog.push_back(a[3] ? 1 : a[2] ? 2 : a[0] ? 3 : 4);
            if (rsp_valid_o != 2'b00) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp", rsp_valid_o, 0);
                else begin
                    r = rsp_q.pop_front();
                    chk("rsp_valid", rsp_valid_o, r.valid);
                    chk("rsp_data", {rsp_hit_o, rsp_is_4M_o, rsp_content_o}, {r.hit, r.big, r.data});
                end
            end
        end
    end

    // ---------------- stimulus
    int          n_fl, n_up;
    int          n_lu[2];
    logic [31:0] d_fl_vaddr;
    logic [AW-1:0] d_fl_asid;
    logic [19:0] d_upd_vpn;
    logic [8:0]  d_upd_asid;
    logic        d_upd_4m;
    logic [31:0] d_upd_data;
    logic [31:0] d_lu_vaddr[2];
    logic [AW-1:0] d_lu_asid[2];

    function automatic logic [19:0] pick_vpn();
        case ($urandom_range(0, 3))
            0: return 20'h00401;
            1: return 20'h00802;
            2: return 20'h00C03;
            default: return 20'h01004;
        endcase
    endfunction

    function automatic logic [31:0] rand_va();
        logic [19:0] v;
        logic [11:0] off;
        v = pick_vpn();
        if ($urandom_range(0, 1) == 1) v[0] = ~v[0];
        off = 12'($urandom);
        return {v, off};
    endfunction

    task automatic run(input bit rnd, input int budget);
        int cyc;
        logic [3:0] a;
        cyc = 0;
        while ((n_fl + n_up + n_lu[0] + n_lu[1]) > 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
            a = s_ack;
            if (a[3]) n_fl--;
            if (a[2]) n_up--;
            if (a[0]) n_lu[0]--;
            if (a[1]) n_lu[1]--;
            #1;
            flush_req_i   = (n_fl > 0);
            flush_vaddr_i = d_fl_vaddr;
            flush_asid_i  = d_fl_asid;
            if (n_up > 0) begin
                if (rnd && a[2] && $urandom_range(0, 2) == 0) upd_req_i = 1'b0;
                else begin
                    if (!rnd) begin
                        upd_vpn_i = d_upd_vpn; upd_asid_i = d_upd_asid;
                        upd_is_4M_i = d_upd_4m; upd_content_i = d_upd_data;
                    end else if (a[2] || !upd_req_i) begin
                        upd_vpn_i = pick_vpn(); upd_asid_i = 9'($urandom_range(0, 1));
                        upd_is_4M_i = 1'($urandom_range(0, 1)); upd_content_i = $urandom;
                    end
                    upd_req_i = 1'b1;
                end
            end else upd_req_i = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (n_lu[p] > 0) begin
                    if (rnd && a[p] && $urandom_range(0, 2) == 0) lu_req_i[p] = 1'b0;
                    else begin
                        if (!rnd) begin
                            lu_vaddr_i[p] = d_lu_vaddr[p]; lu_asid_i[p] = d_lu_asid[p];
                        end else if (a[p] || !lu_req_i[p]) begin
                            lu_vaddr_i[p] = rand_va(); lu_asid_i[p] = AW'($urandom_range(0, 1));
                        end
                        lu_req_i[p] = 1'b1;
                    end
                end else lu_req_i[p] = 1'b0;
            end
        end
        chk("run_timeout", n_fl + n_up + n_lu[0] + n_lu[1], 0);
        n_fl = 0; n_up = 0; n_lu[0] = 0; n_lu[1] = 0;
        flush_req_i = 1'b0; upd_req_i = 1'b0; lu_req_i = 2'b00;
    endtask

    task automatic chk_log(input string name, input int seq[$]);
        chk({name, "_len"}, glog.size(), seq.size());
        foreach (seq[i]) chk(name, (i < glog.size()) ? glog[i] : -1, seq[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        n_fl = 0; n_up = 0; n_lu[0] = 0; n_lu[1] = 0;
        d_fl_vaddr = '0; d_fl_asid = '0;
        d_upd_vpn = '0; d_upd_asid = '0; d_upd_4m = 1'b0; d_upd_data = '0;
        d_lu_vaddr[0] = '0; d_lu_vaddr[1] = '0; d_lu_asid[0] = '0; d_lu_asid[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset asserted while a lookup response is in flight
        @(posedge clk); #1;
        lu_req_i = 2'b01; lu_vaddr_i[0] = 32'h00401000; lu_asid_i[0] = '0;
        @(posedge clk);
        #2 rst_n = 1'b0; lu_req_i = 2'b00;
        #1 chk("rst_drops_rsp", rsp_valid_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin @(negedge clk); #2 chk("no_rsp_after_rst", rsp_valid_o, 0); end

        // update then lookup of the same page
        d_upd_vpn = 20'h12345; d_upd_asid = 9'd1; d_upd_4m = 1'b0; d_upd_data = 32'hDEADBEEF;
        n_up = 1; run(0, 20);
        d_lu_vaddr[0] = 32'h12345000; d_lu_asid[0] = 1'b1;
        n_lu[0] = 1; run(0, 20);
        @(negedge clk); #2;
        chk("upd_lu_hit", {rsp_valid_o, rsp_hit_o, rsp_content_o}, {2'b01, 1'b1, 32'hDEADBEEF});

        // flush everything, then the same page misses
        d_fl_vaddr = '0; d_fl_asid = '0;
        n_fl = 1; run(0, 20);
        d_lu_vaddr[1] = 32'h12345000; d_lu_asid[1] = 1'b1;
        n_lu[1] = 1; run(0, 20);
        @(negedge clk); #2;
        chk("flush_lu_miss", {rsp_valid_o, rsp_hit_o}, {2'b10, 1'b0});

        // all four at once
        glog.delete();
        d_upd_vpn = 20'h00401; d_upd_asid = 9'd0; d_upd_data = 32'h0BADF00D;
        d_lu_vaddr[0] = 32'h00401000; d_lu_asid[0] = 1'b0;
        d_lu_vaddr[1] = 32'h00802000; d_lu_asid[1] = 1'b0;
        n_fl = 1; n_up = 1; n_lu[0] = 1; n_lu[1] = 1;
        run(0, 30);
        chk_log("order", '{1, 2, 3, 4});

        // update streak starves port 1
        glog.delete();
        n_up = 6; n_lu[1] = 2;
        run(0, 40);
        chk_log("starve", '{2, 2, 2, 2, 4, 2, 2, 4});

        // round-robin between both ports
        glog.delete();
        n_lu[0] = 3; n_lu[1] = 3;
        run(0, 30);
        chk_log("rr", '{3, 4, 3, 4, 3, 4});

        // randomized batches
        n_fl = 1; run(0, 20);
        for (int b = 0; b < 25; b++) begin
            n_fl = ($urandom_range(0, 4) == 0) ? 1 : 0;
            n_up = $urandom_range(0, 5);
            n_lu[0] = $urandom_range(0, 6);
            n_lu[1] = $urandom_range(0, 6);
            run(1, 200);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1 chk("rsp_q_empty", rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
